eros_obi_to_axil_bridge: RTL
============================

// Module: eros_obi_to_axil_bridge
// PURPOSE
// Converts the EROS external-slave OBI manager port (ext_slave_req_o/ext_slave_resp_i of eros_top) into an AXI4-Lite
// manager port toward the SoC interconnect. Sits directly downstream of eros_top, on the outbound path.
// Tracks up to MAX_OUTSTANDING transactions and returns OBI responses strictly in request order,
// even when AXI read and write responses complete out of order relative to each other.
// PARAMETERS
// ADDR_WIDTH       32    OBI/AXI address width
// DATA_WIDTH       32    OBI/AXI data width; only 32 is supported (elaboration assertion)
// MAX_OUTSTANDING  4     ordering-FIFO depth; power of 2, >=2 (elaboration assertion)
// AXI_PROT         3'b0  constant driven on awprot/arprot
// PORTS
// clk_i          in   1     clock
// rst_i          in   1     asynchronous reset, active-high
// obi_req_i      in   1     OBI request
// obi_we_i       in   1     1=write, 0=read
// obi_be_i       in   4     byte enables -> wstrb
// obi_addr_i     in   AW    byte address, passed unmodified
// obi_wdata_i    in   32    write data
// obi_gnt_o      out  1     OBI grant (combinational)
// obi_rvalid_o   out  1     OBI response valid (registered)
// obi_rdata_o    out  32    read data; 0 for writes
// obi_err_o      out  1     qualified by rvalid; 1 when AXI resp != OKAY
// m_awaddr_o/m_awprot_o/m_awvalid_o out, m_awready_i in   AW channel
// m_wdata_o/m_wstrb_o/m_wvalid_o    out, m_wready_i  in   W channel
// m_bresp_i[1:0]/m_bvalid_i         in,  m_bready_o  out  B channel
// m_araddr_o/m_arprot_o/m_arvalid_o out, m_arready_i in   AR channel
// m_rdata_i/m_rresp_i[1:0]/m_rvalid_i in, m_rready_o out  R channel
// BEHAVIOUR
// - Reset: all valids, readys, obi_gnt_o, obi_rvalid_o, obi_err_o = 0; rdata and channel payload regs = 0; FIFO empty.
// - Grant (comb): gnt = req & !fifo_full & (we ? (!aw_pend & !w_pend) : !ar_pend).
// - On grant: push txn type (RD/WR) into the ordering FIFO.
//   Write: latch addr -> AW reg and wdata/be -> W reg; set aw_pend and w_pend.
//   Read: latch addr -> AR reg; set ar_pend.
// - Request-to-AXI latency: axVALID/wVALID rise the cycle after gnt and hold with stable payload until their own ready.
//   AW and W handshake independently; each pend flag clears on its handshake.
// - Pend flags hold the grant low, so each channel has at most one un-issued request; the FIFO bounds total outstanding.
// - Response acceptance (comb): bready = !empty & head==WR; rready = !empty & head==RD. A response for the
//   non-head type is stalled at AXI, which preserves OBI ordering.
// - On B or R handshake: pop the FIFO. Next cycle rvalid_o=1 for exactly 1 cycle; rdata_o = rdata (read) or 0 (write);
//   err_o = (resp != 2'b00). At most one response per cycle.
// - Full: gnt=0. Pop and grant in the same cycle while full: the grant stays 0 (full evaluated before the pop).
//   Push and pop in the same cycle while not full: both take effect, count unchanged.
// - Empty: bready=rready=0; a stray bvalid/rvalid stalls indefinitely.
// - FIFO pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.
// - Reset mid-transaction discards pending requests and the FIFO. The AXI subordinate must be reset concurrently.
// - SVA, simulation only:
//   - payload stable while valid & !ready;
//   - no push when full;
//   - rvalid_o is never asserted in two consecutive cycles without two handshakes.
// STRUCTURE
// - eros_obi_axil_pkg: txn_e {TXN_RD, TXN_WR}; AXI_RESP_OKAY = 2'b00; the apb/axil typedef macros' widths.
// - Sub-module eros_obi_axil_order_fifo: 1-bit wide, depth MAX_OUTSTANDING, async active-high reset,
//   push/pop/full/empty/head ports.
// - Top: pend flags, channel payload registers, grant/ready logic, registered response stage.
// TESTING
// 1. Single read 0x0000_1000: AR issued cycle after gnt, arready=1, R(0xDEADBEEF, OKAY)
//    -> rvalid one cycle after R handshake, rdata=0xDEADBEEF, err=0.
// 2. Write 0x10, be=4'b0011, data 0xA5A5: wready 3 cycles before awready
//    -> wstrb=0011, one B accepted, rvalid with rdata=0, err=0.
// 3. 4 back-to-back reads, arready=1, R withheld -> 5th req gets gnt=0 until the first R pops; responses in order.
// 4. Write then read issued; subordinate returns R before B
//    -> rready=0 until B is accepted; OBI sees write response, then read response.
// 5. Read returning rresp=SLVERR with data 0x1234 -> rvalid with err=1, rdata=0x1234.
// 6. rst_i pulse with AW pending and 2 FIFO entries -> all valids 0, gnt available next cycle, FIFO empty.

Source files
------------

// File: rtl/eros_obi_axil_pkg.sv
// Shared types and AXI4-Lite constants for the EROS OBI-to-AXI4-Lite bridge.
package eros_obi_axil_pkg;

    typedef enum logic {
        TXN_RD = 1'b0,
        TXN_WR = 1'b1
    } txn_e;

    localparam int unsigned AXIL_RESP_W   = 2;
    localparam int unsigned AXIL_PROT_W   = 3;
    localparam logic [AXIL_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/eros_obi_axil_order_fifo.sv
// Records the type (read/write) of every granted OBI transaction in issue order so that
// AXI responses are only accepted for the oldest outstanding transaction.
module eros_obi_axil_order_fifo
    import eros_obi_axil_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  txn_e data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output txn_e head_o
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    txn_e             mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= TXN_RD;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/eros_obi_to_axil_bridge.sv
// OBI manager to AXI4-Lite manager bridge; OBI responses are returned strictly in request
// order even when the subordinate completes reads and writes out of order.
module eros_obi_to_axil_bridge
    import eros_obi_axil_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH      = 32,
    parameter int unsigned            DATA_WIDTH      = 32,
    parameter int unsigned            MAX_OUTSTANDING = 4,
    parameter logic [AXIL_PROT_W-1:0] AXI_PROT        = 3'b000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      obi_req_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    output logic                      obi_gnt_o,
    output logic                      obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
    output logic                      obi_err_o,
    output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
    output logic [AXIL_PROT_W-1:0]    m_awprot_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,
    output logic [DATA_WIDTH-1:0]     m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    input  logic [AXIL_RESP_W-1:0]    m_bresp_i,
    input  logic                      m_bvalid_i,
    output logic                      m_bready_o,
    output logic [ADDR_WIDTH-1:0]     m_araddr_o,
    output logic [AXIL_PROT_W-1:0]    m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [DATA_WIDTH-1:0]     m_rdata_i,
    input  logic [AXIL_RESP_W-1:0]    m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);

    if (DATA_WIDTH != 32) begin : g_chk_dw
        $error("eros_obi_to_axil_bridge: DATA_WIDTH must be 32");
    end
    if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_chk_depth
        $error("eros_obi_to_axil_bridge: MAX_OUTSTANDING must be a power of two >= 2");
    end

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  rvalid_q, rvalid_d, err_q, err_d;

    logic fifo_full, fifo_empty;
    txn_e fifo_head;
    logic gnt, b_hs, r_hs, pop;

    // Full is the registered count, so a pop in the same cycle never reopens the grant.
    assign gnt = !rst_i && obi_req_i && !fifo_full &&
                 (obi_we_i ? (!aw_pend_q && !w_pend_q) : !ar_pend_q);

    assign m_bready_o = !fifo_empty && (fifo_head == TXN_WR);
    assign m_rready_o = !fifo_empty && (fifo_head == TXN_RD);
    assign b_hs       = m_bvalid_i && m_bready_o;
    assign r_hs       = m_rvalid_i && m_rready_o;
    assign pop        = b_hs || r_hs;

    eros_obi_axil_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .data_i  (obi_we_i ? TXN_WR : TXN_RD),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        ar_pend_d = ar_pend_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rvalid_d  = pop;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        if (m_awready_i) aw_pend_d = 1'b0;
        if (m_wready_i)  w_pend_d  = 1'b0;
        if (m_arready_i) ar_pend_d = 1'b0;

        if (gnt && obi_we_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            awaddr_d  = obi_addr_i;
            wdata_d   = obi_wdata_i;
            wstrb_d   = obi_be_i;
        end
        if (gnt && !obi_we_i) begin
            ar_pend_d = 1'b1;
            araddr_d  = obi_addr_i;
        end

        if (r_hs) begin
            rdata_d = m_rdata_i;
            err_d   = (m_rresp_i != AXI_RESP_OKAY);
        end else if (b_hs) begin
            rdata_d = '0;
            err_d   = (m_bresp_i != AXI_RESP_OKAY);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            ar_pend_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            ar_pend_q <= ar_pend_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign m_awaddr_o   = awaddr_q;
    assign m_awprot_o   = AXI_PROT;
    assign m_awvalid_o  = aw_pend_q;
    assign m_wdata_o    = wdata_q;
    assign m_wstrb_o    = wstrb_q;
    assign m_wvalid_o   = w_pend_q;
    assign m_araddr_o   = araddr_q;
    assign m_arprot_o   = AXI_PROT;
    assign m_arvalid_o  = ar_pend_q;

`ifndef SYNTHESIS
    a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        m_awvalid_o && !m_awready_i |=> m_awvalid_o && $stable(m_awaddr_o));
    a_w_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        m_wvalid_o && !m_wready_i |=> m_wvalid_o && $stable(m_wdata_o) && $stable(m_wstrb_o));
    a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        m_arvalid_o && !m_arready_i |=> m_arvalid_o && $stable(m_araddr_o));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(gnt && fifo_full));
    a_rvalid_b2b: assert property (@(posedge clk_i) disable iff (rst_i)
        obi_rvalid_o && $past(obi_rvalid_o) |-> $past(pop) && $past(pop, 2));
`endif

endmodule
